// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-through no-write-allocate D-cache controller; ports cpu_* (core), ram_* (data RAM), pipeline_stall_o/cache_data_ack_o; define DCACHE_PERF_CNT_EN to add hit_cnt_o/miss_cnt_o
module dcache_ctrl #(
  parameter int LINE_NUM   = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_rd_req_i,
  input  logic        cpu_wr_req_i,
  input  logic [31:0] cpu_rd_addr_i,
  input  logic [31:0] cpu_wr_addr_i,
  input  logic [31:0] cpu_wr_data_i,
  input  logic [3:0]  cpu_wr_en_i,
  output logic [31:0] cpu_rd_data_o,
  output logic        pipeline_stall_o,
  output logic        cache_data_ack_o,
`ifdef DCACHE_PERF_CNT_EN
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o,
`endif
  output logic [31:0] ram_rd_addr_o,
  input  logic [31:0] ram_rd_data_i,
  output logic [31:0] ram_wr_addr_o,
  output logic [31:0] ram_wr_data_o,
  output logic [3:0]  ram_wr_en_o
);
  localparam int WW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(LINE_NUM);
  localparam int TW = 30 - WW - IW;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;
  state_t state_q, state_d;
  logic [WW:0] cnt_q, cnt_d;
  logic [31:2] addr_q, addr_d, waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d, rd_data_q, rd_data_d, ram_rd_addr_q, ram_rd_addr_d;
  logic [3:0] wen_q, wen_d;
  logic ack_q, ack_d;
  logic [LINE_NUM-1:0] valid_q, valid_d;
  logic [TW-1:0] tag_q [LINE_NUM];
  logic [31:0] data_q [LINE_NUM*LINE_WORDS];
  logic data_we, tag_we, hit_evt, miss_evt, rd_hit, wr_hit, unused_ok;
  logic [IW+WW-1:0] data_wa;
  logic [31:0] data_wd, merged;
  logic [WW-1:0] prev_w, rd_word, a_word, w_word;
  logic [TW-1:0] rd_tag, a_tag, w_tag;
  logic [IW-1:0] rd_idx, a_idx, w_idx;
  assign {rd_tag, rd_idx, rd_word} = cpu_rd_addr_i[31:2];
  assign {a_tag, a_idx, a_word} = addr_q;
  assign {w_tag, w_idx, w_word} = waddr_q;
  assign rd_hit = valid_q[rd_idx] && tag_q[rd_idx] == rd_tag;
  assign wr_hit = valid_q[w_idx] && tag_q[w_idx] == w_tag;
  assign prev_w = cnt_q[WW-1:0] - WW'(1);
  assign cpu_rd_data_o = rd_data_q;
  assign cache_data_ack_o = ack_q;
  assign pipeline_stall_o = !ack_q && (state_q != IDLE || cpu_wr_req_i || (cpu_rd_req_i && !rd_hit));
  assign ram_rd_addr_o = (state_q == REFILL && !cnt_q[WW]) ? {a_tag, a_idx, cnt_q[WW-1:0], 2'b00} : ram_rd_addr_q;
  assign ram_wr_addr_o = {waddr_q, 2'b00};
  assign ram_wr_data_o = wdata_q;
  assign ram_wr_en_o = state_q == WRITE ? wen_q : 4'b0000;
  always_comb begin
    merged = data_q[{w_idx, w_word}];
    for (int b = 0; b < 4; b++)
      if (wen_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wen_d = wen_q;
    rd_data_d = rd_data_q;
    ack_d = 1'b0;
    ram_rd_addr_d = ram_rd_addr_o;
    valid_d = valid_q;
    data_we = 1'b0;
    tag_we = 1'b0;
    data_wa = '0;
    data_wd = '0;
    hit_evt = 1'b0;
    miss_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_wr_req_i) begin
          waddr_d = cpu_wr_addr_i[31:2];
          wdata_d = cpu_wr_data_i;
          wen_d = cpu_wr_en_i;
          state_d = WRITE;
        end else if (cpu_rd_req_i && rd_hit) begin
          rd_data_d = data_q[{rd_idx, rd_word}];
          ack_d = 1'b1;
          hit_evt = 1'b1;
        end else if (cpu_rd_req_i) begin
          addr_d = cpu_rd_addr_i[31:2];
          cnt_d = '0;
          state_d = REFILL;
          miss_evt = 1'b1;
        end
      end
      REFILL: begin
        data_we = cnt_q != '0;
        data_wa = {a_idx, prev_w};
        data_wd = ram_rd_data_i;
        cnt_d = cnt_q + (WW+1)'(1);
        if (cnt_q[WW]) begin
          valid_d[a_idx] = 1'b1;
          tag_we = 1'b1;
          rd_data_d = a_word == prev_w ? ram_rd_data_i : data_q[{a_idx, a_word}];
          ack_d = 1'b1;
          cnt_d = cnt_q;
          state_d = IDLE;
        end
      end
      WRITE: begin
        data_we = wr_hit;
        data_wa = {w_idx, w_word};
        data_wd = merged;
        ack_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wen_q <= '0;
      rd_data_q <= '0;
      ack_q <= 1'b0;
      ram_rd_addr_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wen_q <= wen_d;
      rd_data_q <= rd_data_d;
      ack_q <= ack_d;
      ram_rd_addr_q <= ram_rd_addr_d;
      valid_q <= valid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (data_we) data_q[data_wa] <= data_wd;
    if (tag_we) tag_q[a_idx] <= a_tag;
  end
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  assign hit_cnt_d = hit_cnt_q + 32'(hit_evt);
  assign miss_cnt_d = miss_cnt_q + 32'(miss_evt);
  always_ff @(posedge clk) begin
    hit_cnt_q <= rst ? '0 : hit_cnt_d;
    miss_cnt_q <= rst ? '0 : miss_cnt_d;
  end
  assign hit_cnt_o = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
  assign unused_ok = ^{cpu_rd_addr_i[1:0], cpu_wr_addr_i[1:0]};
`else
  assign unused_ok = ^{cpu_rd_addr_i[1:0], cpu_wr_addr_i[1:0], hit_evt, miss_evt};
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: table-driven plus randomized self-checking bench for dcache_ctrl
module tb_dcache_ctrl;
  localparam int LN = 64;
  localparam int LW = 4;
  logic clk, rst, cpu_rd_req_i, cpu_wr_req_i, pipeline_stall_o, cache_data_ack_o;
  logic [31:0] cpu_rd_addr_i, cpu_wr_addr_i, cpu_wr_data_i, cpu_rd_data_o;
  logic [31:0] ram_rd_addr_o, ram_rd_data_i, ram_wr_addr_o, ram_wr_data_o;
  logic [3:0] cpu_wr_en_i, ram_wr_en_o;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_o, miss_cnt_o;
`endif
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_data [LN*LW];
  bit m_valid [LN];
  int unsigned m_tag [LN];
  int m_hits, m_misses;
  typedef struct {
    bit wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0] en;
    int lat;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [13];
  dcache_ctrl #(.LINE_NUM(LN), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd_req_i(cpu_rd_req_i), .cpu_wr_req_i(cpu_wr_req_i),
    .cpu_rd_addr_i(cpu_rd_addr_i), .cpu_wr_addr_i(cpu_wr_addr_i),
    .cpu_wr_data_i(cpu_wr_data_i), .cpu_wr_en_i(cpu_wr_en_i),
    .cpu_rd_data_o(cpu_rd_data_o), .pipeline_stall_o(pipeline_stall_o),
    .cache_data_ack_o(cache_data_ack_o),
`ifdef DCACHE_PERF_CNT_EN
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o),
`endif
    .ram_rd_addr_o(ram_rd_addr_o), .ram_rd_data_i(ram_rd_data_i),
    .ram_wr_addr_o(ram_wr_addr_o), .ram_wr_data_o(ram_wr_data_o),
    .ram_wr_en_o(ram_wr_en_o)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) ram_rd_data_i <= 32'h1111_0000 + ram_rd_addr_o;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  function automatic void model_reset();
    for (int i = 0; i < LN; i++) m_valid[i] = 0;
    m_hits = 0;
    m_misses = 0;
  endfunction
  function automatic void model(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] en, output int lat, output logic [31:0] rdata);
    int unsigned w, word, idx, tag, base;
    bit hit;
    w = addr >> 2;
    word = w % LW;
    idx = (w / LW) % LN;
    tag = w / (LW * LN);
    hit = m_valid[idx] && m_tag[idx] == tag;
    rdata = 0;
    if (wr) begin
      lat = 2;
      if (hit)
        for (int b = 0; b < 4; b++)
          if (en[b]) m_data[idx*LW+word][8*b +: 8] = data[8*b +: 8];
    end else if (hit) begin
      lat = 1;
      rdata = m_data[idx*LW+word];
      m_hits++;
    end else begin
      lat = LW + 2;
      base = addr & ~(LW*4 - 1);
      for (int i = 0; i < LW; i++) m_data[idx*LW+i] = 32'h1111_0000 + base + 4*i;
      m_valid[idx] = 1;
      m_tag[idx] = tag;
      rdata = m_data[idx*LW+word];
      m_misses++;
    end
  endfunction
  task automatic run_access(input bit wr, input bit rd_too, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] en, input int exp_lat, input logic [31:0] exp_data);
    int k, bad_stall;
    bit seen;
    logic [31:0] line, prev_rd;
    line = addr & ~(32'(LW*4) - 1);
    prev_rd = ram_rd_addr_o;
    if (wr) begin
      cpu_wr_req_i = 1;
      cpu_wr_addr_i = addr;
      cpu_wr_data_i = data;
      cpu_wr_en_i = en;
      cpu_rd_req_i = rd_too;
      cpu_rd_addr_i = $urandom;
    end else begin
      cpu_rd_req_i = 1;
      cpu_rd_addr_i = addr;
    end
    #1 chk("stall_req", {31'd0, pipeline_stall_o}, {31'd0, exp_lat > 1});
    seen = 0;
    bad_stall = 0;
    k = 0;
    while (!seen && k < 20) begin
      cyc();
      k++;
      if (cache_data_ack_o) begin
        seen = 1;
        cpu_rd_req_i = 0;
        cpu_wr_req_i = 0;
        #1;
      end else begin
        if (!pipeline_stall_o) bad_stall++;
        if (!wr && exp_lat > 1 && k <= LW) chk("ram_rd_addr", ram_rd_addr_o, line + 32'(4*(k-1)));
        if (wr && k == 1) begin
          chk("ram_wr_en", {28'd0, ram_wr_en_o}, {28'd0, en});
          chk("ram_wr_addr", ram_wr_addr_o, addr & ~32'd3);
          chk("ram_wr_data", ram_wr_data_o, data);
        end
      end
    end
    chk("ack_seen", {31'd0, seen}, 32'd1);
    if (!seen) begin
      cpu_rd_req_i = 0;
      cpu_wr_req_i = 0;
    end else begin
      chk("latency", k, exp_lat);
      chk("stall_at_ack", {31'd0, pipeline_stall_o}, 32'd0);
      chk("wr_en_idle", {28'd0, ram_wr_en_o}, 32'd0);
      if (!wr) chk("rd_data", cpu_rd_data_o, exp_data);
      if (!wr && exp_lat == 1) chk("no_ram_rd", ram_rd_addr_o, prev_rd);
    end
    chk("stall_hold", bad_stall, 0);
    cyc();
    chk("ack_pulse", {31'd0, cache_data_ack_o}, 32'd0);
  endtask
  initial begin
    int lat;
    logic [31:0] d, a;
    bit wr;
    tbl[0]  = '{0, 32'h0000_0100, 32'h0, 4'h0, 6, 32'h1111_0100};
    tbl[1]  = '{0, 32'h0000_0108, 32'h0, 4'h0, 1, 32'h1111_0108};
    tbl[2]  = '{1, 32'h0000_0104, 32'hAABB_CCDD, 4'b0011, 2, 32'h0};
    tbl[3]  = '{0, 32'h0000_0104, 32'h0, 4'h0, 1, 32'h1111_CCDD};
    tbl[4]  = '{1, 32'h0000_4000, 32'h1234_5678, 4'b1111, 2, 32'h0};
    tbl[5]  = '{0, 32'h0000_4000, 32'h0, 4'h0, 6, 32'h1111_4000};
    tbl[6]  = '{0, 32'h0000_0500, 32'h0, 4'h0, 6, 32'h1111_0500};
    tbl[7]  = '{0, 32'h0000_0100, 32'h0, 4'h0, 6, 32'h1111_0100};
    tbl[8]  = '{1, 32'h0000_010C, 32'hFFFF_FFFF, 4'b0000, 2, 32'h0};
    tbl[9]  = '{0, 32'h0000_010C, 32'h0, 4'h0, 1, 32'h1111_010C};
    tbl[10] = '{1, 32'h0000_010C, 32'hDEAD_BEEF, 4'b1100, 2, 32'h0};
    tbl[11] = '{0, 32'h0000_010C, 32'h0, 4'h0, 1, 32'hDEAD_010C};
    tbl[12] = '{0, 32'h0000_020C, 32'h0, 4'h0, 6, 32'h1111_020C};
    rst = 1;
    cpu_rd_req_i = 0;
    cpu_wr_req_i = 0;
    cpu_rd_addr_i = 0;
    cpu_wr_addr_i = 0;
    cpu_wr_data_i = 0;
    cpu_wr_en_i = 0;
    model_reset();
    repeat (3) cyc();
    chk("rst_ack", {31'd0, cache_data_ack_o}, 32'd0);
    chk("rst_stall", {31'd0, pipeline_stall_o}, 32'd0);
    chk("rst_rd_data", cpu_rd_data_o, 32'd0);
    chk("rst_ram_rd_addr", ram_rd_addr_o, 32'd0);
    chk("rst_ram_wr_addr", ram_wr_addr_o, 32'd0);
    chk("rst_ram_wr_data", ram_wr_data_o, 32'd0);
    chk("rst_ram_wr_en", {28'd0, ram_wr_en_o}, 32'd0);
    rst = 0;
    cyc();
    for (int i = 0; i < 13; i++) begin
      model(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].en, lat, d);
      run_access(tbl[i].wr, 0, tbl[i].addr, tbl[i].data, tbl[i].en, tbl[i].lat, tbl[i].exp);
    end
    cpu_rd_req_i = 1;
    cpu_rd_addr_i = 32'h0000_0900;
    repeat (3) cyc();
    rst = 1;
    cpu_rd_req_i = 0;
    cyc();
    model_reset();
    chk("abort_ack", {31'd0, cache_data_ack_o}, 32'd0);
    chk("abort_stall", {31'd0, pipeline_stall_o}, 32'd0);
    chk("abort_ram_rd_addr", ram_rd_addr_o, 32'd0);
    chk("abort_rd_data", cpu_rd_data_o, 32'd0);
`ifdef DCACHE_PERF_CNT_EN
    chk("rst_hit_cnt", hit_cnt_o, 32'd0);
    chk("rst_miss_cnt", miss_cnt_o, 32'd0);
`endif
    rst = 0;
    cyc();
    chk("abort_no_ack", {31'd0, cache_data_ack_o}, 32'd0);
    model(0, 32'h0000_0100, 0, 0, lat, d);
    run_access(0, 0, 32'h0000_0100, 0, 0, 6, 32'h1111_0100);
    model(0, 32'h0000_0900, 0, 0, lat, d);
    run_access(0, 0, 32'h0000_0900, 0, 0, 6, 32'h1111_0900);
    for (int i = 0; i < 150; i++) begin
      wr = $urandom_range(0, 9) < 3;
      a = 32'(((($urandom_range(0, 3) * LN) + $urandom_range(0, 7)) * LW + $urandom_range(0, LW-1)) * 4 + $urandom_range(0, 3));
      d = $urandom;
      cpu_wr_en_i = 4'($urandom_range(0, 15));
      begin
        logic [31:0] rd_exp;
        logic [3:0] en;
        en = cpu_wr_en_i;
        model(wr, a, d, en, lat, rd_exp);
        run_access(wr, 1'($urandom_range(0, 1)), a, d, en, lat, rd_exp);
      end
    end
`ifdef DCACHE_PERF_CNT_EN
    chk("hit_cnt", hit_cnt_o, 32'(m_hits));
    chk("miss_cnt", miss_cnt_o, 32'(m_misses));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
